// File: rtl/truth_table_checker.sv
// rtl/truth_table_checker.sv - exhaustive 3-input law checker comparing lhs_in/rhs_in over all vectors
// Optional feature: define TT_CHECK_LOOP_EN to restart automatically one cycle after each DONE.
module truth_table_checker #(
   parameter int unsigned SETTLE = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       lhs_in,
   input  logic       rhs_in,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] mismatch_cnt,
   output logic       fail_valid,
   output logic [2:0] first_fail
);

   typedef enum logic [1:0] {IDLE, HOLD, CHECK, DONE} state_t;

   localparam logic [3:0] HOLD_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
   localparam state_t     FIRST_ST  = (SETTLE == 0) ? CHECK : HOLD;

   state_t     state_q;
   logic [2:0] vec_q;
   logic [3:0] hold_q;
   logic [3:0] cnt_q;
   logic [3:0] cnt_d;
   logic       busy_q;
   logic       done_q;
   logic       pass_q;
   logic       fv_q;
   logic [2:0] ff_q;
   logic       miss;
   logic       restart;

   assign miss  = lhs_in ^ rhs_in;
   assign cnt_d = cnt_q + {3'b000, miss};

`ifdef TT_CHECK_LOOP_EN
   // DONE lasts exactly one cycle, then behaves as if start were asserted
   assign restart = (state_q == DONE) || (state_q == IDLE && start);
`else
   assign restart = start && (state_q == IDLE || state_q == DONE);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         vec_q   <= 3'b000;
         hold_q  <= 4'd0;
         cnt_q   <= 4'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         fv_q    <= 1'b0;
         ff_q    <= 3'b000;
      end else if (restart) begin
         state_q <= FIRST_ST;
         vec_q   <= 3'b000;
         hold_q  <= 4'd0;
         cnt_q   <= 4'd0;
         busy_q  <= 1'b1;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         fv_q    <= 1'b0;
         ff_q    <= 3'b000;
      end else begin
         case (state_q)
            HOLD: begin
               if (hold_q == HOLD_LAST) begin
                  hold_q  <= 4'd0;
                  state_q <= CHECK;
               end else begin
                  hold_q <= hold_q + 4'd1;
               end
            end
            CHECK: begin
               cnt_q <= cnt_d;
               if (miss && !fv_q) begin
                  fv_q <= 1'b1;
                  ff_q <= vec_q;
               end
               // pass uses the updated count so it is valid in the same cycle as done
               if (vec_q == 3'b111) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= (cnt_d == 4'd0);
               end else begin
                  vec_q   <= vec_q + 3'd1;
                  state_q <= FIRST_ST;
               end
            end
            default: ;
         endcase
      end
   end

   assign a            = vec_q[2];
   assign b            = vec_q[1];
   assign c            = vec_q[0];
   assign busy         = busy_q;
   assign done         = done_q;
   assign pass         = pass_q;
   assign mismatch_cnt = cnt_q;
   assign fail_valid   = fv_q;
   assign first_fail   = ff_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// tb/tb_truth_table_checker.sv - table-driven bench for truth_table_checker (SETTLE=0 and SETTLE=1 instances)
module tb_truth_table_checker;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rhs_zero = 1'b0;
   logic [1:0] start_v = 2'b00;
   logic [1:0] lhs_v, rhs_v, a_v, b_v, c_v, busy_v, done_v, pass_v, fv_v;
   logic [3:0] cnt_v [2];
   logic [2:0] ff_v  [2];

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   // law under test: a&(b|c), optionally compared against a constant 0
   for (genvar i = 0; i < 2; i++) begin : g_law
      assign lhs_v[i] = a_v[i] & (b_v[i] | c_v[i]);
      assign rhs_v[i] = rhs_zero ? 1'b0 : lhs_v[i];
   end

   truth_table_checker #(.SETTLE(0)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]), .lhs_in(lhs_v[0]), .rhs_in(rhs_v[0]),
      .a(a_v[0]), .b(b_v[0]), .c(c_v[0]), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
      .mismatch_cnt(cnt_v[0]), .fail_valid(fv_v[0]), .first_fail(ff_v[0])
   );

   truth_table_checker #(.SETTLE(1)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]), .lhs_in(lhs_v[1]), .rhs_in(rhs_v[1]),
      .a(a_v[1]), .b(b_v[1]), .c(c_v[1]), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
      .mismatch_cnt(cnt_v[1]), .fail_valid(fv_v[1]), .first_fail(ff_v[1])
   );

   typedef struct {
      int         dut;
      bit         rz;
      logic [3:0] cnt;
      logic       fv;
      logic [2:0] ff;
      logic       pass;
      int         mid_vec;
   } vec_t;

   vec_t tbl [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [2:0] vec_of(input int d);
      return {a_v[d], b_v[d], c_v[d]};
   endfunction

   task automatic check_all_zero(input string name);
      for (int d = 0; d < 2; d++)
         chk(name, {vec_of(d), busy_v[d], done_v[d], pass_v[d], cnt_v[d], fv_v[d], ff_v[d]}, 32'd0);
   endtask

   // one full run on DUT d with the exact per-cycle schedule checked
   task automatic run(input vec_t t);
      int hold = (t.dut == 1) ? 2 : 1;
      int n    = 8 * hold;
      int mid  = (t.mid_vec < 0) ? -1 : t.mid_vec * hold;
      rhs_zero = t.rz;
      start_v[t.dut] = 1'b1;
      @(posedge clk);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         start_v[t.dut] = (k == mid);
         if (k == 0)
            chk("cleared", {cnt_v[t.dut], fv_v[t.dut], ff_v[t.dut], pass_v[t.dut]}, 32'd0);
         chk("vector", vec_of(t.dut), 32'(k / hold));
         chk("busy_done", {busy_v[t.dut], done_v[t.dut]}, 32'b10);
      end
      @(negedge clk);
      start_v[t.dut] = 1'b0;
      chk("end_busy_done", {busy_v[t.dut], done_v[t.dut]}, 32'b01);
      chk("end_vector", vec_of(t.dut), 32'd7);
      chk("mismatch_cnt", cnt_v[t.dut], t.cnt);
      chk("fail_valid", fv_v[t.dut], t.fv);
      chk("first_fail", ff_v[t.dut], t.ff);
      chk("pass", pass_v[t.dut], t.pass);
   endtask

   initial begin
      tbl[0] = '{1, 1'b0, 4'd0, 1'b0, 3'd0, 1'b1, -1};
      tbl[1] = '{1, 1'b1, 4'd3, 1'b1, 3'd5, 1'b0, -1};
      tbl[2] = '{1, 1'b1, 4'd3, 1'b1, 3'd5, 1'b0, 4};
      tbl[3] = '{1, 1'b0, 4'd0, 1'b0, 3'd0, 1'b1, 4};
      tbl[4] = '{0, 1'b0, 4'd0, 1'b0, 3'd0, 1'b1, -1};
      tbl[5] = '{0, 1'b1, 4'd3, 1'b1, 3'd5, 1'b0, 4};

      #1;
      check_all_zero("reset_state");
      @(negedge clk);
      rst_n = 1'b1;

`ifdef TT_CHECK_LOOP_EN
      run(tbl[0]);
      for (int p = 0; p < 2; p++) begin
         for (int cyc = 1; cyc <= 17; cyc++) begin
            @(negedge clk);
            chk("loop_done", done_v[1], (cyc == 17) ? 32'd1 : 32'd0);
         end
         chk("loop_pass", pass_v[1], 32'd1);
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_all_zero("loop_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("loop_idle_after_reset", {busy_v[1], done_v[1]}, 32'd0);
`else
      for (int i = 0; i < 6; i++) begin
         run(tbl[i]);
         repeat (3) @(negedge clk);
         chk("done_held", {done_v[tbl[i].dut], vec_of(tbl[i].dut)}, 32'hF);
      end

      // asynchronous reset while DUT 1 shows vector 011
      rhs_zero = 1'b0;
      start_v[1] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_v[1] = 1'b0;
      repeat (6) @(negedge clk);
      chk("pre_reset_vector", vec_of(1), 32'd3);
      rst_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      run(tbl[0]);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/truth_table_checker.md
TRUTH_TABLE_CHECKER -- requirements
Module: truth_table_checker

Interface
REQ-001 SHALL have parameter SETTLE, default 1, giving the number of idle cycles each vector is held before it is sampled (range 0..15).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous reset, active-low.
REQ-004 SHALL have port start  input  1  request one exhaustive check run.
REQ-005 SHALL have port lhs_in  input  1  left-hand result returned by the combinational law block under test.
REQ-006 SHALL have port rhs_in  input  1  right-hand result returned by the same block.
REQ-007 SHALL have ports a, b, c  output  1 each  registered test vector driven to the block under test (a is the MSB).
REQ-008 SHALL have port busy  output  1  run in progress.
REQ-009 SHALL have port done  output  1  run complete; results valid.
REQ-010 SHALL have port pass  output  1  done and zero mismatches.
REQ-011 SHALL have port mismatch_cnt  output  4  number of vectors where lhs_in != rhs_in.
REQ-012 SHALL have port fail_valid  output  1  at least one mismatch recorded this run.
REQ-013 SHALL have port first_fail  output  3  {a,b,c} of the first mismatching vector.

Function
REQ-014 SHALL implement FSM states IDLE, HOLD, CHECK, DONE.
REQ-015 In IDLE or DONE, start=1 SHALL load vector 000, clear mismatch_cnt, fail_valid, first_fail, done, and pass, and go to HOLD (SETTLE>0) or CHECK (SETTLE=0).
REQ-016 In HOLD, the block SHALL count SETTLE cycles, then go to CHECK. The vector SHALL stay stable.
REQ-017 In CHECK, the block SHALL sample lhs_in and rhs_in once. If they differ, it SHALL increment mismatch_cnt and, if fail_valid=0, capture the current vector into first_fail and set fail_valid.
REQ-018 After CHECK of vectors 000..110, the block SHALL increment the vector and return to HOLD (or to CHECK if SETTLE=0).
REQ-019 After CHECK of vector 111, the block SHALL go to DONE and assert done on the next edge. pass SHALL equal (mismatch_cnt==0) in that same cycle.
REQ-020 Each vector SHALL be held for exactly SETTLE+1 cycles. Done SHALL rise 8*(SETTLE+1) cycles after the edge that accepted start.
REQ-021 busy SHALL be 1 exactly in HOLD and CHECK. done and busy SHALL never both be 1.
REQ-022 start SHALL be ignored while busy=1.
REQ-023 mismatch_cnt SHALL be limited by design to 0..8 and SHALL never wrap.
REQ-024 The vector SHALL wrap from 111 to 000 only on a new start (or loop, see REQ-028). It SHALL otherwise hold 111 in DONE.

Reset
REQ-025 rst_n=0 SHALL immediately force state IDLE, a=b=c=0, busy=0, done=0, pass=0, mismatch_cnt=0, fail_valid=0, first_fail=000, and the hold counter to 0, including mid-run.
REQ-026 After release of rst_n, the block SHALL accept start on the first rising edge.

Configuration
REQ-027 Without TT_CHECK_LOOP_EN, DONE SHALL be held until the next start.
REQ-028 With TT_CHECK_LOOP_EN defined, on entering DONE the block SHALL stay there exactly one cycle (done=1 for one cycle), then automatically restart as if start were asserted. Results SHALL clear on the restart. Reset SHALL still return the block to IDLE.

Verification
REQ-029 SETTLE=1, lhs_in=rhs_in=a&(b|c) -> vectors 000..111 each held 2 cycles; done=1 at cycle 16 after start; pass=1, mismatch_cnt=0, fail_valid=0.
REQ-030 SETTLE=1, lhs_in=a&(b|c), rhs_in tied 0 -> mismatch_cnt=3, fail_valid=1, first_fail=101, pass=0.
REQ-031 SETTLE=0 with a matched pair -> done=1 8 cycles after start, each vector visible for 1 cycle.
REQ-032 rst_n pulsed low during vector 011 -> all outputs 0 asynchronously; a new start yields a full clean run with pass=1.
REQ-033 start pulsed again at vector 100 mid-run -> ignored; the run completes on the original schedule. start in DONE -> results cleared and a new run begins.
REQ-034 TT_CHECK_LOOP_EN defined, matched pair, SETTLE=1 -> done pulses for 1 cycle every 17 cycles with pass=1 on each pulse.
